soc_system_txd_serializer: RTL
==============================

Name: soc_system_txd_serializer

Overview:
- UART 8N1 transmitter sitting directly downstream of the HPS-written 32-bit TXD output PIO.
- Decodes the PIO word as a byte plus toggle-style push and clear commands, and queues bytes in a small FIFO.
- Serializes queued bytes gap-free onto a txd pin.
- Exposes a 32-bit status word intended for an input PIO, so software can poll level, busy and overflow.

Parameters:
- CLK_HZ, 50000000, input clock frequency in Hz.
- BAUD, 115200, line rate in bit/s.
  - DIV = round(CLK_HZ/BAUD) cycles per bit.
  - DIV >= 2 is required; elaboration error otherwise.
- FIFO_DEPTH, 8, byte FIFO entries; power of 2, 2..16.

Ports:
- clk  in  1  system clock; single clock domain, same clock as the PIO.
- reset  in  1  asynchronous, active-high reset.
- pio_word  in  32  TXD PIO out_port.
  - [7:0] data byte.
  - [8] push toggle.
  - [9] clear toggle.
  - [31:10] ignored.
- txd  out  1  serial output, idle high, registered.
- tx_busy  out  1  high while a frame is on the line (state != IDLE).
- status  out  32  status word:
  - [4:0] FIFO level.
  - [8] busy.
  - [9] full.
  - [10] empty.
  - [11] overflow sticky.
  - [23:16] frames-sent counter, mod 256.
  - All other bits 0.

Behaviour:
- Reset values: txd=1, tx_busy=0, status=0x00000400 (empty=1); FIFO flushed; prev_push=0, prev_clr=0; state IDLE.
- Command detect:
  - push = pio_word[8] ^ prev_push; clr = pio_word[9] ^ prev_clr.
  - prev_* registered every cycle.
  - Changes to [7:0] alone do nothing.
- Push write:
  - A push is written at the first edge after pio_word changes, with data = pio_word[7:0] at that edge.
- Overflow:
  - Push while full with no pop at the same edge: byte dropped, overflow sticky set.
  - Push and pop at the same edge while full: push accepted, level unchanged.
- Clear:
  - Flushes the FIFO (level=0) and clears overflow.
  - Does not abort the frame in flight.
  - Clear and push at the same edge: clear wins, byte dropped, overflow not set.
- FSM states: IDLE, START, DATA, STOP. baud_cnt counts 0..DIV-1.
  - IDLE: when FIFO is not empty, pop into shift register, txd<=0, go START, baud_cnt=0. Start bit is on the line at the pop edge plus 1 cycle.
  - START: at baud_cnt=DIV-1, txd<=shreg[0], go DATA with bit_idx=0.
  - DATA: each DIV cycles, shift LSB first. After bit 7 has held DIV cycles, txd<=1 and go STOP.
  - STOP at baud_cnt=DIV-1:
    - Increment frames counter.
    - If the FIFO is not empty: pop, txd<=0, go START (no idle gap).
    - Otherwise go IDLE.
- Frame length is exactly 10*DIV cycles.
- Level arithmetic: level = wr_ptr - rd_ptr, using pointers of width log2(DEPTH)+1. Pointers wrap naturally; full when level == DEPTH.
- Reset asserted mid-frame: txd high immediately (asynchronous), FIFO and counters cleared. No start bit until a new push after release.

Decomposition:
- Package soc_system_txd_pkg holds:
  - Field positions PUSH_BIT=8, CLR_BIT=9, DATA_LSB/MSB.
  - Status bit positions.
  - State enum type txd_state_t.
- Sub-module soc_system_txd_fifo: synchronous FIFO with parameter DEPTH.
  - Ports: wr, wdata, rd, rdata, flush, level, full, empty.
  - Push-while-full is ignored internally; overflow detection lives in the top.
- Top contains command detect, FSM, baud counter and status assembly.

Test Plan (CLK_HZ=1000, BAUD=100 → DIV=10, FIFO_DEPTH=8):
1. Reset -> txd=1, tx_busy=0, status=0x00000400. Drive pio_word=0x000000FF without toggling -> no push, level stays 0.
2. pio_word 0x000 -> 0x1A5 -> start bit begins 2 edges later.
   - txd = 0,1,0,1,0,0,1,0,1,1, each held 10 cycles; frame is 100 cycles.
   - Afterwards status = 0x00010400.
3. Push 0x01, 0x02, 0x03 on consecutive toggles -> three contiguous frames, 300 cycles, no high gap beyond each stop bit; counter = 3.
4. Push 10 bytes, one every 2 cycles, starting at idle:
   - Byte0 popped immediately; bytes 1-8 fill the FIFO; byte 9 dropped.
   - status[4:0]=8, full=1, overflow=1.
   - Exactly 9 frames are sent.
5. Five bytes queued mid-frame, then toggle bit 9:
   - level=0, overflow=0.
   - The current frame completes intact, then IDLE with txd=1.
   - Clear and push on the same edge -> level stays 0.
6. Assert reset during DATA bit 4 -> txd=1 within the same cycle, status=0x00000400. After release with no push, txd stays 1 for 200 cycles.

Source files
------------

// File: rtl/soc_system_txd_pkg.sv
// Shared field positions, status layout and FSM state type for the TXD serializer.
package soc_system_txd_pkg;

  // PIO command word layout
  localparam int DATA_LSB = 0;
  localparam int DATA_MSB = 7;
  localparam int PUSH_BIT = 8;
  localparam int CLR_BIT  = 9;

  // Status word layout
  localparam int STAT_LEVEL_LSB  = 0;
  localparam int STAT_LEVEL_MSB  = 4;
  localparam int STAT_BUSY_BIT   = 8;
  localparam int STAT_FULL_BIT   = 9;
  localparam int STAT_EMPTY_BIT  = 10;
  localparam int STAT_OVF_BIT    = 11;
  localparam int STAT_FRAMES_LSB = 16;
  localparam int STAT_FRAMES_MSB = 23;

  // state    | meaning
  // ST_IDLE  | line idle high, waiting for a queued byte
  // ST_START | start bit (low) on the line
  // ST_DATA  | data bits, LSB first
  // ST_STOP  | stop bit (high); may chain straight into the next start bit
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } txd_state_t;

  // Cycles per bit, rounded to nearest.
  function automatic int baud_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/soc_system_txd_fifo.sv
// Small synchronous byte FIFO with show-ahead read data and a flush input.
// Writes while full are dropped unless a read happens at the same edge.
module soc_system_txd_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr,
  input  logic [7:0]               wdata,
  input  logic                     rd,
  output logic [7:0]               rdata,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = DEPTH[AW:0];

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]  mem_q [DEPTH];
  logic        wr_en;
  logic        rd_en;

  // Level/flag decode and pointer advance; flush overrides everything.
  always_comb begin
    level    = wr_ptr_q - rd_ptr_q;
    full     = (level == FULL_LEVEL);
    empty    = (level == '0);
    rd_en    = rd & ~empty;
    wr_en    = wr & (~full | rd_en);
    rdata    = mem_q[rd_ptr_q[AW-1:0]];
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (wr_en && !flush) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/soc_system_txd_serializer.sv
// UART 8N1 transmitter fed by a toggle-command PIO word, with byte FIFO and
// a status word for software polling.
module soc_system_txd_serializer #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pio_word,
  output logic        txd,
  output logic        tx_busy,
  output logic [31:0] status
);

  import soc_system_txd_pkg::*;

  localparam int DIV = baud_div(CLK_HZ, BAUD);
  localparam int CW  = (DIV < 2) ? 1 : $clog2(DIV);
  localparam int LW  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);

  if (DIV < 2) begin : g_bad_div
    $error("soc_system_txd_serializer: CLK_HZ/BAUD must give at least 2 cycles per bit");
  end
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("soc_system_txd_serializer: FIFO_DEPTH must be a power of 2 in 2..16");
  end

  txd_state_t    state_q, state_d;
  logic [CW-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          txd_q, txd_d;
  logic [7:0]    frames_q, frames_d;
  logic          overflow_q, overflow_d;
  logic          prev_push_q, prev_push_d;
  logic          prev_clr_q, prev_clr_d;

  logic          push_cmd;
  logic          clr_cmd;
  logic          fifo_wr;
  logic          pop;
  logic          baud_last;
  logic [7:0]    fifo_rdata;
  logic [LW-1:0] fifo_level;
  logic          fifo_full;
  logic          fifo_empty;
  logic          unused_pio;

  assign unused_pio = ^pio_word[31:10];

  soc_system_txd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (fifo_wr),
    .wdata (pio_word[DATA_MSB:DATA_LSB]),
    .rd    (pop),
    .rdata (fifo_rdata),
    .flush (clr_cmd),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Toggle-edge command decode; a clear in the same cycle swallows the push.
  always_comb begin
    prev_push_d = pio_word[PUSH_BIT];
    prev_clr_d  = pio_word[CLR_BIT];
    push_cmd    = pio_word[PUSH_BIT] ^ prev_push_q;
    clr_cmd     = pio_word[CLR_BIT] ^ prev_clr_q;
    fifo_wr     = push_cmd & ~clr_cmd;
    overflow_d  = overflow_q;
    if (clr_cmd) begin
      overflow_d = 1'b0;
    end else if (push_cmd && fifo_full && !pop) begin
      overflow_d = 1'b1;
    end
  end

  // Frame FSM: next state, baud counter, shifter and line level.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    shreg_d    = shreg_q;
    txd_d      = txd_q;
    frames_d   = frames_q;
    pop        = 1'b0;
    baud_last  = (baud_cnt_q == BAUD_LAST);
    case (state_q)
      ST_IDLE: begin
        txd_d = 1'b1;
        if (!fifo_empty) begin
          pop        = 1'b1;
          shreg_d    = fifo_rdata;
          txd_d      = 1'b0;
          baud_cnt_d = '0;
          state_d    = ST_START;
        end
      end
      ST_START: begin
        if (baud_last) begin
          txd_d      = shreg_q[0];
          shreg_d    = shreg_q >> 1;
          bit_idx_d  = '0;
          baud_cnt_d = '0;
          state_d    = ST_DATA;
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (baud_last) begin
          baud_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            txd_d   = 1'b1;
            state_d = ST_STOP;
          end else begin
            txd_d     = shreg_q[0];
            shreg_d   = shreg_q >> 1;
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (baud_last) begin
          frames_d   = frames_q + 8'd1;
          baud_cnt_d = '0;
          if (!fifo_empty) begin
            // Chain the next frame with no idle gap after the stop bit.
            pop     = 1'b1;
            shreg_d = fifo_rdata;
            txd_d   = 1'b0;
            state_d = ST_START;
          end else begin
            txd_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
      default: begin
        txd_d   = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; txd resets high so the line idles instantly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      baud_cnt_q  <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      txd_q       <= 1'b1;
      frames_q    <= '0;
      overflow_q  <= 1'b0;
      prev_push_q <= 1'b0;
      prev_clr_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_cnt_q  <= baud_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      txd_q       <= txd_d;
      frames_q    <= frames_d;
      overflow_q  <= overflow_d;
      prev_push_q <= prev_push_d;
      prev_clr_q  <= prev_clr_d;
    end
  end

  // Output and status word assembly.
  always_comb begin
    txd     = txd_q;
    tx_busy = (state_q != ST_IDLE);
    status  = '0;
    status[STAT_LEVEL_MSB:STAT_LEVEL_LSB]   = 5'(fifo_level);
    status[STAT_BUSY_BIT]                   = tx_busy;
    status[STAT_FULL_BIT]                   = fifo_full;
    status[STAT_EMPTY_BIT]                  = fifo_empty;
    status[STAT_OVF_BIT]                    = overflow_q;
    status[STAT_FRAMES_MSB:STAT_FRAMES_LSB] = frames_q;
  end

endmodule
